// File: rtl/pcs_rx_pkg.sv
// Shared PCS RX definitions: coded block width, sync header encodings and helpers.
package pcs_rx_pkg;

   localparam int unsigned LEN_CODED_BLOCK = 66;
   localparam int unsigned LEN_SH          = 2;

   localparam logic [LEN_SH-1:0] SH_DATA = 2'b01;
   localparam logic [LEN_SH-1:0] SH_CTRL = 2'b10;

   typedef enum logic [1:0] {
      FILL_EMPTY   = 2'd0,
      FILL_FILLING = 2'd1,
      FILL_FULL    = 2'd2
   } fill_state_e;

   function automatic logic sh_is_invalid(input logic [LEN_SH-1:0] header);
      return (header != SH_DATA) && (header != SH_CTRL);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int unsigned      WIDTH = 16,
   parameter logic [WIDTH-1:0] MAX   = '1
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (i_clr) begin
         count_d = '0;
      end else if (i_inc && (count_q != MAX)) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign o_count = count_q;

endmodule

// File: rtl/decoder_lookahead_window.sv
// DEPTH-deep window of coded blocks feeding the RX decoder, with per-stage valid,
// fill tracking, flush and a saturating invalid-sync-header counter.
module decoder_lookahead_window #(
   parameter int unsigned LEN_CODED_BLOCK = pcs_rx_pkg::LEN_CODED_BLOCK,
   parameter int unsigned DEPTH           = 2,
   parameter int unsigned NB_FILL         = 4,
   parameter int unsigned NB_SH_ERR       = 16
) (
   input  logic                             i_clock,
   input  logic                             i_reset,
   input  logic                             i_enable,
   input  logic                             i_flush,
   input  logic                             i_sh_err_clr,
   input  logic [LEN_CODED_BLOCK-1:0]       i_rx_coded,
   output logic [LEN_CODED_BLOCK-1:0]       o_rx_coded,
   output logic [LEN_CODED_BLOCK-1:0]       o_rx_coded_next,
   output logic [DEPTH*LEN_CODED_BLOCK-1:0] o_window,
   output logic [DEPTH-1:0]                 o_valid,
   output logic                             o_window_full,
   output logic [NB_FILL-1:0]               o_fill,
   output logic [NB_SH_ERR-1:0]             o_sh_err_count
);

   import pcs_rx_pkg::*;

   localparam int unsigned LEN = LEN_CODED_BLOCK;

   logic [LEN-1:0]       stage_q [DEPTH];
   logic [LEN-1:0]       stage_d [DEPTH];
   logic [DEPTH-1:0]     valid_q;
   logic [DEPTH-1:0]     valid_d;
   logic                 full_q;
   logic                 full_d;
   logic [NB_FILL-1:0]   fill_q;
   logic [NB_SH_ERR-1:0] sh_err_q;
   logic                 accept_c;
   logic                 sh_bad_c;
   fill_state_e          fill_state_c;

   assign accept_c = i_enable & ~i_flush;
   assign sh_bad_c = accept_c & sh_is_invalid(i_rx_coded[LEN-1 -: LEN_SH]);

   // Window shift: stage 0 is the oldest block, the newest enters at DEPTH-1.
   always_comb begin
      stage_d = stage_q;
      valid_d = valid_q;
      if (i_flush) begin
         for (int k = 0; k < DEPTH; k++) begin
            stage_d[k] = '0;
         end
         valid_d = '0;
      end else if (i_enable) begin
         for (int k = 0; k < DEPTH - 1; k++) begin
            stage_d[k] = stage_q[k+1];
         end
         stage_d[DEPTH-1] = i_rx_coded;
         valid_d          = {1'b1, valid_q[DEPTH-1:1]};
      end
   end

   always_comb begin
      fill_state_c = FILL_FILLING;
      if (fill_q == '0) begin
         fill_state_c = FILL_EMPTY;
      end else if (fill_q == NB_FILL'(DEPTH)) begin
         fill_state_c = FILL_FULL;
      end
   end

   // Full flag tracks the fill counter's next value so it stays registered.
   always_comb begin
      full_d = (fill_state_c == FILL_FULL);
      if (i_flush) begin
         full_d = 1'b0;
      end else if (i_enable && (fill_q == NB_FILL'(DEPTH - 1))) begin
         full_d = 1'b1;
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         for (int k = 0; k < DEPTH; k++) begin
            stage_q[k] <= '0;
         end
         valid_q <= '0;
         full_q  <= 1'b0;
      end else begin
         stage_q <= stage_d;
         valid_q <= valid_d;
         full_q  <= full_d;
      end
   end

   sat_counter #(
      .WIDTH (NB_FILL),
      .MAX   (NB_FILL'(DEPTH))
   ) u_fill_cnt (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_inc   (accept_c),
      .i_clr   (i_flush),
      .o_count (fill_q)
   );

   sat_counter #(
      .WIDTH (NB_SH_ERR)
   ) u_sh_err_cnt (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_inc   (sh_bad_c),
      .i_clr   (i_sh_err_clr),
      .o_count (sh_err_q)
   );

   always_comb begin
      o_window = '0;
      for (int k = 0; k < DEPTH; k++) begin
         o_window[k*LEN +: LEN] = stage_q[k];
      end
   end

   assign o_rx_coded      = stage_q[0];
   assign o_rx_coded_next = stage_q[1];
   assign o_valid         = valid_q;
   assign o_window_full   = full_q;
   assign o_fill          = fill_q;
   assign o_sh_err_count  = sh_err_q;

endmodule

// File: tb/tb_decoder_lookahead_window.sv
// Scoreboard bench for decoder_lookahead_window: four instances (DEPTH 2/4/3 and a
// 2-bit header-error counter) driven by directed vectors with hand-computed results.
module tb_decoder_lookahead_window;

   localparam int unsigned L = 66;

   typedef struct packed {
      logic [1:0]     sel;
      logic [4*L-1:0] win;
      logic [7:0]     valid;
      logic [3:0]     fill;
      logic           full;
      logic [15:0]    sh;
   } exp_t;

   logic         clk;
   logic         rst;
   logic [3:0]   en;
   logic [3:0]   fl;
   logic [3:0]   clr;
   logic [L-1:0] din;

   exp_t  exp_q[$];
   string name_q[$];
   int    total;
   int    bad;

   // Instance 0: DEPTH=2
   logic [L-1:0]   d2_cur, d2_nxt;
   logic [2*L-1:0] d2_win;
   logic [1:0]     d2_val;
   logic           d2_full;
   logic [3:0]     d2_fill;
   logic [15:0]    d2_sh;
   // Instance 1: DEPTH=4
   logic [L-1:0]   d4_cur, d4_nxt;
   logic [4*L-1:0] d4_win;
   logic [3:0]     d4_val;
   logic           d4_full;
   logic [3:0]     d4_fill;
   logic [15:0]    d4_sh;
   // Instance 2: DEPTH=3
   logic [L-1:0]   d3_cur, d3_nxt;
   logic [3*L-1:0] d3_win;
   logic [2:0]     d3_val;
   logic           d3_full;
   logic [3:0]     d3_fill;
   logic [15:0]    d3_sh;
   // Instance 3: DEPTH=2, NB_SH_ERR=2
   logic [L-1:0]   ds_cur, ds_nxt;
   logic [2*L-1:0] ds_win;
   logic [1:0]     ds_val;
   logic           ds_full;
   logic [3:0]     ds_fill;
   logic [1:0]     ds_sh;

   decoder_lookahead_window #(.DEPTH(2), .NB_FILL(4), .NB_SH_ERR(16)) u_d2 (
      .i_clock(clk), .i_reset(rst), .i_enable(en[0]), .i_flush(fl[0]),
      .i_sh_err_clr(clr[0]), .i_rx_coded(din), .o_rx_coded(d2_cur),
      .o_rx_coded_next(d2_nxt), .o_window(d2_win), .o_valid(d2_val),
      .o_window_full(d2_full), .o_fill(d2_fill), .o_sh_err_count(d2_sh));

   decoder_lookahead_window #(.DEPTH(4), .NB_FILL(4), .NB_SH_ERR(16)) u_d4 (
      .i_clock(clk), .i_reset(rst), .i_enable(en[1]), .i_flush(fl[1]),
      .i_sh_err_clr(clr[1]), .i_rx_coded(din), .o_rx_coded(d4_cur),
      .o_rx_coded_next(d4_nxt), .o_window(d4_win), .o_valid(d4_val),
      .o_window_full(d4_full), .o_fill(d4_fill), .o_sh_err_count(d4_sh));

   decoder_lookahead_window #(.DEPTH(3), .NB_FILL(4), .NB_SH_ERR(16)) u_d3 (
      .i_clock(clk), .i_reset(rst), .i_enable(en[2]), .i_flush(fl[2]),
      .i_sh_err_clr(clr[2]), .i_rx_coded(din), .o_rx_coded(d3_cur),
      .o_rx_coded_next(d3_nxt), .o_window(d3_win), .o_valid(d3_val),
      .o_window_full(d3_full), .o_fill(d3_fill), .o_sh_err_count(d3_sh));

   decoder_lookahead_window #(.DEPTH(2), .NB_FILL(4), .NB_SH_ERR(2)) u_ds (
      .i_clock(clk), .i_reset(rst), .i_enable(en[3]), .i_flush(fl[3]),
      .i_sh_err_clr(clr[3]), .i_rx_coded(din), .o_rx_coded(ds_cur),
      .o_rx_coded_next(ds_nxt), .o_window(ds_win), .o_valid(ds_val),
      .o_window_full(ds_full), .o_fill(ds_fill), .o_sh_err_count(ds_sh));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One accepting/idle cycle on instance sel; inputs are dropped right after the edge.
   task automatic step(input int sel, input logic e, input logic f, input logic c,
                       input logic [L-1:0] d);
      @(negedge clk);
      en = '0; fl = '0; clr = '0;
      en[sel]  = e;
      fl[sel]  = f;
      clr[sel] = c;
      din      = d;
      @(posedge clk);
      #1;
      en = '0; fl = '0; clr = '0;
   endtask

   task automatic chk(input int sel, input string nm,
                      input logic [L-1:0] s0, input logic [L-1:0] s1,
                      input logic [L-1:0] s2, input logic [L-1:0] s3,
                      input logic [7:0] v, input logic [3:0] f, input logic fu,
                      input logic [15:0] sh);
      exp_t e;
      e.sel   = 2'(sel);
      e.win   = {s3, s2, s1, s0};
      e.valid = v;
      e.fill  = f;
      e.full  = fu;
      e.sh    = sh;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // Monitor: drains every expectation queued before this falling edge.
   initial begin
      exp_t           e;
      string          nm;
      logic [L-1:0]   a_cur, a_nxt;
      logic [4*L-1:0] a_win;
      logic [7:0]     a_val;
      logic [3:0]     a_fill;
      logic           a_full;
      logic [15:0]    a_sh;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            case (e.sel)
               2'd0: begin
                  a_cur = d2_cur; a_nxt = d2_nxt; a_win = (4*L)'(d2_win);
                  a_val = 8'(d2_val); a_fill = d2_fill; a_full = d2_full; a_sh = d2_sh;
               end
               2'd1: begin
                  a_cur = d4_cur; a_nxt = d4_nxt; a_win = d4_win;
                  a_val = 8'(d4_val); a_fill = d4_fill; a_full = d4_full; a_sh = d4_sh;
               end
               2'd2: begin
                  a_cur = d3_cur; a_nxt = d3_nxt; a_win = (4*L)'(d3_win);
                  a_val = 8'(d3_val); a_fill = d3_fill; a_full = d3_full; a_sh = d3_sh;
               end
               default: begin
                  a_cur = ds_cur; a_nxt = ds_nxt; a_win = (4*L)'(ds_win);
                  a_val = 8'(ds_val); a_fill = ds_fill; a_full = ds_full; a_sh = 16'(ds_sh);
               end
            endcase
            total++;
            if (a_cur !== e.win[L-1:0] || a_nxt !== e.win[2*L-1:L] || a_win !== e.win ||
                a_val !== e.valid || a_fill !== e.fill || a_full !== e.full ||
                a_sh !== e.sh) begin
               bad++;
               $display("FAIL %s: got win=%h valid=%b fill=%0d full=%0d sh=%0d cur=%h nxt=%h; want win=%h valid=%b fill=%0d full=%0d sh=%0d",
                        nm, a_win, a_val, a_fill, a_full, a_sh, a_cur, a_nxt,
                        e.win, e.valid, e.fill, e.full, e.sh);
            end
         end
      end
   end

   initial begin
      logic [L-1:0] z;
      logic [L-1:0] a, b, c, p1, p2, p3, p4, p5, bd;
      logic [L-1:0] ha, hb, hc, hd, he, hf;
      logic [L-1:0] q1, q2, q3, q4, q5, q6, r1, x, y, zz;

      z  = '0;
      a  = 66'h1_0000_0000_0000_00AA;
      b  = 66'h1_0000_0000_0000_00BB;
      c  = 66'h1_0000_0000_0000_00CC;
      p1 = 66'h2_1111_0000_0000_0001;
      p2 = 66'h2_2222_0000_0000_0002;
      p3 = 66'h2_3333_0000_0000_0003;
      p4 = 66'h2_4444_0000_0000_0004;
      p5 = 66'h2_5555_0000_0000_0005;
      bd = 66'h0_DDDD_DDDD_DDDD_DDDD;
      ha = 66'h0_A000_0000_0000_000A;
      hb = 66'h3_B000_0000_0000_000B;
      hc = 66'h1_C000_0000_0000_000C;
      hd = 66'h2_D000_0000_0000_000D;
      he = 66'h0_E000_0000_0000_000E;
      hf = 66'h3_F000_0000_0000_000F;
      q1 = 66'h0_0000_0000_0000_0011;
      q2 = 66'h3_0000_0000_0000_0022;
      q3 = 66'h0_0000_0000_0000_0033;
      q4 = 66'h3_0000_0000_0000_0044;
      q5 = 66'h0_0000_0000_0000_0055;
      q6 = 66'h3_0000_0000_0000_0066;
      r1 = 66'h1_7777_8888_9999_AAAA;
      x  = 66'h1_0123_4567_89AB_CDEF;
      y  = 66'h2_FEDC_BA98_7654_3210;
      zz = 66'h1_5A5A_A5A5_5A5A_A5A5;

      total = 0;
      bad   = 0;
      en = '0; fl = '0; clr = '0; din = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk(0, "reset_d2", z, z, z, z, 8'b00, 4'd0, 1'b0, 16'd0);
      chk(1, "reset_d4", z, z, z, z, 8'b0000, 4'd0, 1'b0, 16'd0);
      chk(2, "reset_d3", z, z, z, z, 8'b000, 4'd0, 1'b0, 16'd0);
      chk(3, "reset_ds", z, z, z, z, 8'b00, 4'd0, 1'b0, 16'd0);
      @(negedge clk);
      rst = 1'b0;

      // DEPTH=2 classic coded/coded_next pair
      step(0, 1'b1, 1'b0, 1'b0, a); chk(0, "d2_a", z, a, z, z, 8'b10, 4'd1, 1'b0, 16'd0);
      step(0, 1'b1, 1'b0, 1'b0, b); chk(0, "d2_ab", a, b, z, z, 8'b11, 4'd2, 1'b1, 16'd0);
      step(0, 1'b1, 1'b0, 1'b0, c); chk(0, "d2_bc", b, c, z, z, 8'b11, 4'd2, 1'b1, 16'd0);

      // DEPTH=4 with idle gaps between accepts
      step(1, 1'b1, 1'b0, 1'b0, p1); chk(1, "d4_p1", z, z, z, p1, 8'b1000, 4'd1, 1'b0, 16'd0);
      step(1, 1'b0, 1'b0, 1'b0, bd); chk(1, "d4_gap1", z, z, z, p1, 8'b1000, 4'd1, 1'b0, 16'd0);
      step(1, 1'b1, 1'b0, 1'b0, p2); chk(1, "d4_p2", z, z, p1, p2, 8'b1100, 4'd2, 1'b0, 16'd0);
      step(1, 1'b0, 1'b0, 1'b0, bd); chk(1, "d4_gap2", z, z, p1, p2, 8'b1100, 4'd2, 1'b0, 16'd0);
      step(1, 1'b1, 1'b0, 1'b0, p3); chk(1, "d4_p3", z, p1, p2, p3, 8'b1110, 4'd3, 1'b0, 16'd0);
      step(1, 1'b0, 1'b0, 1'b0, bd); chk(1, "d4_gap3", z, p1, p2, p3, 8'b1110, 4'd3, 1'b0, 16'd0);
      step(1, 1'b1, 1'b0, 1'b0, p4); chk(1, "d4_p4", p1, p2, p3, p4, 8'b1111, 4'd4, 1'b1, 16'd0);
      step(1, 1'b0, 1'b0, 1'b0, bd); chk(1, "d4_gap4", p1, p2, p3, p4, 8'b1111, 4'd4, 1'b1, 16'd0);
      step(1, 1'b1, 1'b0, 1'b0, p5); chk(1, "d4_p5", p2, p3, p4, p5, 8'b1111, 4'd4, 1'b1, 16'd0);

      // Flush beats a simultaneous enable carrying a bad-header block
      step(1, 1'b1, 1'b1, 1'b0, bd); chk(1, "d4_flush", z, z, z, z, 8'b0000, 4'd0, 1'b0, 16'd0);

      // Header counting: 00, 11, 01, 10, 00 -> 3
      step(1, 1'b1, 1'b0, 1'b0, ha); chk(1, "sh_00", z, z, z, ha, 8'b1000, 4'd1, 1'b0, 16'd1);
      step(1, 1'b1, 1'b0, 1'b0, hb); chk(1, "sh_11", z, z, ha, hb, 8'b1100, 4'd2, 1'b0, 16'd2);
      step(1, 1'b1, 1'b0, 1'b0, hc); chk(1, "sh_01", z, ha, hb, hc, 8'b1110, 4'd3, 1'b0, 16'd2);
      step(1, 1'b1, 1'b0, 1'b0, hd); chk(1, "sh_10", ha, hb, hc, hd, 8'b1111, 4'd4, 1'b1, 16'd2);
      step(1, 1'b1, 1'b0, 1'b0, he); chk(1, "sh_00b", hb, hc, hd, he, 8'b1111, 4'd4, 1'b1, 16'd3);
      step(1, 1'b1, 1'b0, 1'b1, hf); chk(1, "sh_clr", hc, hd, he, hf, 8'b1111, 4'd4, 1'b1, 16'd0);

      // 2-bit header-error counter saturates at 3, then clears over a bad header
      step(3, 1'b1, 1'b0, 1'b0, q1); chk(3, "sat_1", z, q1, z, z, 8'b10, 4'd1, 1'b0, 16'd1);
      step(3, 1'b1, 1'b0, 1'b0, q2); chk(3, "sat_2", q1, q2, z, z, 8'b11, 4'd2, 1'b1, 16'd2);
      step(3, 1'b1, 1'b0, 1'b0, q3); chk(3, "sat_3", q2, q3, z, z, 8'b11, 4'd2, 1'b1, 16'd3);
      step(3, 1'b1, 1'b0, 1'b0, q4); chk(3, "sat_4", q3, q4, z, z, 8'b11, 4'd2, 1'b1, 16'd3);
      step(3, 1'b1, 1'b0, 1'b0, q5); chk(3, "sat_5", q4, q5, z, z, 8'b11, 4'd2, 1'b1, 16'd3);
      step(3, 1'b1, 1'b0, 1'b1, q6); chk(3, "sat_clr", q5, q6, z, z, 8'b11, 4'd2, 1'b1, 16'd0);

      // Asynchronous reset mid-cycle on a full window
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk(1, "async_rst", z, z, z, z, 8'b0000, 4'd0, 1'b0, 16'd0);
      @(negedge clk);
      #1;
      rst = 1'b0;
      step(1, 1'b1, 1'b0, 1'b0, r1); chk(1, "refill", z, z, z, r1, 8'b1000, 4'd1, 1'b0, 16'd0);

      // DEPTH=3 window packing
      step(2, 1'b1, 1'b0, 1'b0, x); chk(2, "d3_x", z, z, x, z, 8'b100, 4'd1, 1'b0, 16'd0);
      step(2, 1'b1, 1'b0, 1'b0, y); chk(2, "d3_xy", z, x, y, z, 8'b110, 4'd2, 1'b0, 16'd0);
      step(2, 1'b1, 1'b0, 1'b0, zz); chk(2, "d3_xyz", x, y, zz, z, 8'b111, 4'd3, 1'b1, 16'd0);

      @(negedge clk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
